// File: rtl/y86_branch_predictor_if.sv
// Fetch-lookup and memory-stage training signals of the Y86-64 branch predictor.
// The master modport drives fetch/update inputs; the slave modport is the predictor.
interface y86_branch_predictor_if #(
  parameter int unsigned ADDR_W = 64
);
  logic [ADDR_W-1:0] f_pc;
  logic [3:0]        f_icode;
  logic [3:0]        f_ifun;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic [ADDR_W-1:0] f_predPC;
  logic              f_pred_taken;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic              upd_pred_taken;
  logic              mispredict;

  modport master (
    output f_pc, f_icode, f_ifun, f_valC, f_valP,
    output upd_valid, upd_pc, upd_taken, upd_pred_taken,
    input  f_predPC, f_pred_taken, mispredict
  );

  modport slave (
    input  f_pc, f_icode, f_ifun, f_valC, f_valP,
    input  upd_valid, upd_pc, upd_taken, upd_pred_taken,
    output f_predPC, f_pred_taken, mispredict
  );
endinterface

// File: rtl/y86_branch_predictor.sv
// Tagged saturating-counter branch predictor for the Y86-64 fetch stage.
// Optional macro BP_PERF_CNT_EN adds perf_lookups / perf_mispred counters.
module y86_branch_predictor #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CTR_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  y86_branch_predictor_if.slave bp
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]           perf_lookups,
  output logic [31:0]           perf_mispred
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TOP_W = IDX_W + TAG_W;

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];

  logic [IDX_W-1:0]   f_idx;
  logic [TAG_W-1:0]   f_tag;
  logic [IDX_W-1:0]   u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               f_hit;
  logic               u_hit;
  logic [ADDR_W-1:0]  pred_pc;
  logic               pred_taken;
  logic               mispredict_c;

  assign f_idx = bp.f_pc[IDX_W-1:0];
  assign f_tag = bp.f_pc[TOP_W-1:IDX_W];
  assign u_idx = bp.upd_pc[IDX_W-1:0];
  assign u_tag = bp.upd_pc[TOP_W-1:IDX_W];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  generate
    if (TOP_W < ADDR_W) begin : g_upper
      logic unused_upper_bits;
      assign unused_upper_bits = ^{bp.f_pc[ADDR_W-1:TOP_W], bp.upd_pc[ADDR_W-1:TOP_W]};
    end
  endgenerate

  // Fetch lookup: reads pre-update table contents, no bypass from training
  always_comb begin
    pred_pc    = bp.f_valP;
    pred_taken = 1'b0;
    if ((bp.f_icode == I_CALL) || ((bp.f_icode == I_JXX) && (bp.f_ifun == 4'h0))) begin
      pred_taken = 1'b1;
      pred_pc    = bp.f_valC;
    end else if (bp.f_icode == I_JXX) begin
      pred_taken = f_hit ? ctr_q[f_idx][CTR_W-1] : 1'b1;
      pred_pc    = pred_taken ? bp.f_valC : bp.f_valP;
    end
  end

  assign mispredict_c    = bp.upd_valid && (bp.upd_taken != bp.upd_pred_taken);
  assign bp.f_predPC     = pred_pc;
  assign bp.f_pred_taken = pred_taken;
  assign bp.mispredict   = mispredict_c;

  // Training: saturating count on a tag hit, otherwise (re)allocate the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (bp.upd_valid) begin
      if (u_hit) begin
        if (bp.upd_taken) begin
          if (ctr_q[u_idx] != CTR_MAX) ctr_q[u_idx] <= ctr_q[u_idx] + CTR_W'(1);
        end else begin
          if (ctr_q[u_idx] != '0) ctr_q[u_idx] <= ctr_q[u_idx] - CTR_W'(1);
        end
      end else begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        ctr_q[u_idx]   <= bp.upd_taken ? CTR_WT : CTR_WNT;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lookups <= '0;
      perf_mispred <= '0;
    end else begin
      if (bp.upd_valid && (perf_lookups != 32'hFFFF_FFFF)) perf_lookups <= perf_lookups + 32'd1;
      if (mispredict_c && (perf_mispred != 32'hFFFF_FFFF)) perf_mispred <= perf_mispred + 32'd1;
    end
  end
`endif

endmodule
